// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_if
//  Purpose  : Hazard/stall request and pipeline-control response bundle
//             between the pipeline stages and the pipe_ctrl block.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
  // Requests from the pipeline stages
  logic       id_stall_req;
  logic       ex_br_flush;
  logic       ex_mc_start;
  logic [3:0] ex_mc_cycles;
  logic       ext_halt;

  // Control responses back to the pipeline
  logic [5:0]  stall;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        ex_mc_last;
  logic        busy;
  logic [15:0] stall_cnt;

  // Requester side (pipeline / testbench)
  modport master (
    output id_stall_req, ex_br_flush, ex_mc_start, ex_mc_cycles, ext_halt,
    input  stall, flush_if_id, flush_id_ex, ex_mc_last, busy, stall_cnt
  );

  // Controller side (pipe_ctrl)
  modport slave (
    input  id_stall_req, ex_br_flush, ex_mc_start, ex_mc_cycles, ext_halt,
    output stall, flush_if_id, flush_id_ex, ex_mc_last, busy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Central pipeline hazard controller. Arbitrates halt, multi-cycle
//             EX ops, branch flushes and load-use stalls into a per-stage hold
//             vector plus flush strobes, with zero-cycle request latency.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
  input  wire         clk,
  input  wire         rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MC_BUSY = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  // Hold patterns: stall[k]=1 with stall[k+1]=0 bubbles the register after k
  localparam logic [5:0] C_STALL_ALL  = 6'b111111;  // freeze everything
  localparam logic [5:0] C_STALL_MC   = 6'b001111;  // hold PC..EX/MEM, drain MEM/WB
  localparam logic [5:0] C_STALL_LU   = 6'b000111;  // bubble into ID/EX
  localparam logic [15:0] C_CNT_MAX   = 16'hFFFF;

  state_t      state_q, state_d;
  logic [3:0]  mc_cnt_q, mc_cnt_d;
  logic [15:0] stall_cnt_q;

  logic [5:0]  stall_c;
  logic        flush_if_id_c;
  logic        flush_id_ex_c;
  logic        ex_mc_last_c;
  logic        busy_c;

  // State and multi-cycle down-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Next-state and combinational control outputs (reset forces all low)
  always_comb begin
    state_d       = state_q;
    mc_cnt_d      = mc_cnt_q;
    stall_c       = 6'b000000;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    ex_mc_last_c  = 1'b0;
    busy_c        = 1'b0;

    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (bus.ext_halt) begin
            stall_c = C_STALL_ALL;
            state_d = S_HALT;
          end else if (bus.ex_mc_start && (bus.ex_mc_cycles != 4'd0)) begin
            stall_c = C_STALL_MC;
            if (bus.ex_mc_cycles == 4'd1) begin
              // Single-cycle op completes in the start cycle itself
              ex_mc_last_c = 1'b1;
            end else begin
              // This cycle is stall #1; MC_BUSY covers the remaining N-1
              mc_cnt_d = bus.ex_mc_cycles - 4'd2;
              state_d  = S_MC_BUSY;
            end
          end else if (bus.ex_br_flush) begin
            // Any same-cycle load-use request is on the wrong path
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
          end else if (bus.id_stall_req) begin
            stall_c = C_STALL_LU;
          end
        end

        S_MC_BUSY: begin
          busy_c  = 1'b1;
          stall_c = C_STALL_MC;
          if (mc_cnt_q == 4'd0) begin
            ex_mc_last_c = 1'b1;
            // A halt raised during the op is honoured only once it ends
            state_d      = bus.ext_halt ? S_HALT : S_IDLE;
          end else begin
            mc_cnt_d = mc_cnt_q - 4'd1;
          end
        end

        S_HALT: begin
          busy_c = 1'b1;
          if (bus.ext_halt) begin
            stall_c = C_STALL_ALL;
          end else begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d  = S_IDLE;
          mc_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_c[0] && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush_if_id = flush_if_id_c;
  assign bus.flush_id_ex = flush_id_ex_c;
  assign bus.ex_mc_last  = ex_mc_last_c;
  assign bus.busy        = busy_c;
  assign bus.stall_cnt   = rst ? 16'd0 : stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl: directed scenarios plus
//             randomized traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Behavioural model: remaining stall cycles of an op, halt flag, counter
  int m_mc_rem;
  bit m_halted;
  int m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, compare, advance model
  task automatic step(input bit r, input bit h, input bit s,
                      input logic [3:0] n, input bit fl, input bit ld);
    logic [5:0] e_stall;
    bit e_fi, e_fe, e_last, e_busy;
    int e_cnt;

    @(negedge clk);
    rst              = r;
    bus.ext_halt     = h;
    bus.ex_mc_start  = s;
    bus.ex_mc_cycles = n;
    bus.ex_br_flush  = fl;
    bus.id_stall_req = ld;
    #1;

    e_stall = 6'd0; e_fi = 0; e_fe = 0; e_last = 0; e_busy = 0;
    e_cnt   = r ? 0 : m_cnt;

    if (r) begin
      m_mc_rem = 0; m_halted = 0; m_cnt = 0;
    end else if (m_mc_rem > 0) begin
      e_stall = 6'b001111; e_busy = 1; e_last = (m_mc_rem == 1);
      m_mc_rem--;
      if (m_mc_rem == 0 && h) m_halted = 1;
    end else if (m_halted) begin
      e_busy = 1;
      if (h) e_stall = 6'b111111;
      else   m_halted = 0;
    end else if (h) begin
      e_stall = 6'b111111; m_halted = 1;
    end else if (s && n != 0) begin
      e_stall = 6'b001111; e_last = (n == 1); m_mc_rem = int'(n) - 1;
    end else if (fl) begin
      e_fi = 1; e_fe = 1;
    end else if (ld) begin
      e_stall = 6'b000111;
    end

    check_val("stall",       32'(bus.stall),       32'(e_stall));
    check_val("flush_if_id", 32'(bus.flush_if_id), 32'(e_fi));
    check_val("flush_id_ex", 32'(bus.flush_id_ex), 32'(e_fe));
    check_val("ex_mc_last",  32'(bus.ex_mc_last),  32'(e_last));
    check_val("busy",        32'(bus.busy),        32'(e_busy));
    check_val("stall_cnt",   32'(bus.stall_cnt),   32'(e_cnt));
    check_val("flush_vs_pc_hold",
              32'((bus.flush_if_id | bus.flush_id_ex) & bus.stall[0]), 32'd0);

    if (!r && e_stall[0] && m_cnt < 65535) m_cnt++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 4'd0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 4'd0, 0, 0);
    step(1, 1, 1, 4'd5, 1, 1);  // other inputs must be ignored under reset
  endtask

  initial begin
    bit hold_halt;
    n_checks = 0; n_errors = 0;
    m_mc_rem = 0; m_halted = 0; m_cnt = 0;
    rst = 1'b1;
    bus.ext_halt = 0; bus.ex_mc_start = 0; bus.ex_mc_cycles = 0;
    bus.ex_br_flush = 0; bus.id_stall_req = 0;

    do_reset();

    // Multi-cycle op N=4: four stall cycles, last in the fourth
    step(0, 0, 1, 4'd4, 0, 0);
    step(0, 0, 1, 4'd9, 1, 1);  // ignored during MC_BUSY
    idle(3);
    check_val("mc4_stall_cnt", 32'(bus.stall_cnt), 32'd4);

    // N=1 then N=0 with load-use
    step(0, 0, 1, 4'd1, 0, 0);
    step(0, 0, 1, 4'd0, 0, 1);
    // Branch flush with simultaneous load-use
    step(0, 0, 0, 4'd0, 1, 1);
    step(0, 0, 0, 4'd0, 0, 1);
    idle(1);

    // Halt raised during N=3 op, deferred, then flush pulsed inside HALT
    step(0, 0, 1, 4'd3, 0, 0);
    step(0, 1, 0, 4'd0, 0, 0);
    step(0, 1, 0, 4'd0, 0, 0);
    step(0, 1, 0, 4'd0, 0, 0);
    step(0, 1, 0, 4'd0, 1, 1);
    step(0, 1, 0, 4'd0, 0, 0);
    step(0, 0, 0, 4'd0, 1, 0);  // HALT exit cycle: still ignores flush
    step(0, 0, 0, 4'd0, 1, 0);  // IDLE: flush takes effect
    idle(1);

    // Reset in the second cycle of an N=8 op
    step(0, 0, 1, 4'd8, 0, 0);
    step(1, 0, 0, 4'd0, 0, 0);
    idle(3);
    check_val("post_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Reset mid-HALT
    step(0, 1, 0, 4'd0, 0, 0);
    step(0, 1, 0, 4'd0, 0, 0);
    step(1, 1, 0, 4'd0, 0, 0);
    step(0, 0, 0, 4'd0, 0, 0);
    idle(2);

    // Randomized traffic
    hold_halt = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, s, fl, ld;
      logic [3:0] n;
      if ($urandom_range(99) < 6) hold_halt = ~hold_halt;
      r  = ($urandom_range(99) < 2);
      s  = ($urandom_range(99) < 15);
      n  = 4'($urandom_range(15));
      fl = ($urandom_range(99) < 20);
      ld = ($urandom_range(99) < 30);
      step(r, hold_halt, s, n, fl, ld);
    end

    // Saturation of the stall counter under a long halt
    do_reset();
    for (int i = 0; i < 65540; i++) step(0, 1, 0, 4'd0, 0, 0);
    check_val("sat_stall_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
    step(0, 1, 0, 4'd0, 0, 0);
    step(0, 0, 0, 4'd0, 0, 0);
    idle(2);
    check_val("sat_hold_stall_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
